eab_agu: RTL and testbench
==========================

// Module: eab_agu
// PURPOSE
//  Parametrised, registered successor to the LC-3 effective-address adder.
//  Computes EA = base (PC or Ra) + sign-extended IR offset, with optional one-level indirection (LDI/STI) via a memory read.
//  Sits between decode and the MAR path.
//  Valid/ready handshake on input and output; memory port uses req/ack.
// PARAMETERS
//  DATA_W   16       address/data width; must be >= 12
//  SYS_END  'h3000   first user-space address (ACV check, EAB_ACV_EN only)
//  IO_BASE  'hFE00   first I/O-page address (ACV check, EAB_ACV_EN only)
// PORTS
//  clk        in   1       single clock; all state on rising edge
//  reset      in   1       asynchronous, active-high
//  in_valid   in   1       request valid
//  in_ready   out  1       block can accept (high only in IDLE)
//  ir         in   11      IR[10:0]
//  ra         in   DATA_W  base register value
//  pc         in   DATA_W  PC value
//  sel_eab1   in   1       1=Ra, 0=PC
//  sel_eab2   in   2       00=0, 01=sext(ir[10:0]), 10=sext(ir[8:0]), 11=sext(ir[5:0])
//  indirect   in   1       1: EA is a pointer; result = mem[EA]
//  mem_req    out  1       memory read request
//  mem_addr   out  DATA_W  read address
//  mem_ack    in   1       read done; mem_rdata valid this cycle
//  mem_rdata  in   DATA_W  read data
//  out_valid  out  1       ea_out valid
//  out_ready  in   1       consumer takes ea_out
//  ea_out     out  DATA_W  final effective address
//  user_mode  in   1       [EAB_ACV_EN] privilege of request
//  acv        out  1       [EAB_ACV_EN] access violation flag, qualified by out_valid
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; mem_req=0; out_valid=0; ea_out=0; mem_addr=0; acv=0.
//   Reset is asynchronous and takes effect mid-operation: an outstanding mem_req drops at once and any later mem_ack is ignored.
//  FSM: IDLE -> CALC -> (DONE | IND) ; IND -> DONE ; DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&&in_ready, capture ir/ra/pc/sels/indirect(/user_mode); go CALC.
//    Later input changes have no effect.
//   CALC: register ea = base + off, modulo 2^DATA_W (carry dropped).
//    indirect=0 -> DONE with ea_out=ea. indirect=1 -> IND with mem_req=1, mem_addr=ea.
//   IND: hold mem_req and mem_addr until mem_ack is sampled high.
//    Then ea_out=mem_rdata, mem_req=0, go DONE. No timeout.
//   DONE: out_valid=1; ea_out stable until out_ready is sampled high, then go IDLE.
//  Latency (no backpressure), counting from the accept edge k:
//   direct: out_valid high after edge k+2.
//   indirect: mem_req high after edge k+2; out_valid high one edge after the mem_ack edge.
//  Boundaries:
//   in_valid outside IDLE is ignored (in_ready=0).
//   out_ready in DONE returns to IDLE; the next accept is no earlier than the following edge.
//   mem_ack outside IND is ignored. out_ready without out_valid is ignored.
//  Sign extension: offset MSB replicated up to DATA_W; sel_eab2=00 gives offset 0.
// CONFIGURATION
//  Macro EAB_ACV_EN.
//   Defined: user_mode/acv ports exist.
//    In CALC, if user_mode and (ea<SYS_END or ea>=IO_BASE): go DONE with acv=1 and ea_out=ea; no mem_req is issued.
//    For indirect, the pointer-read result gets the same check in IND; on violation acv=1 and ea_out=mem_rdata.
//   Undefined: ports absent, no checks, behaviour otherwise identical.
// TESTING
//  1. pc=0x3000, sel_eab1=0, sel_eab2=10, ir[8:0]=0x1FF -> ea_out=0x2FFF, out_valid after edge k+2.
//  2. ra=0xFFFF, sel_eab1=1, sel_eab2=11, ir[5:0]=0x01 -> ea_out=0x0000 (wrap); sel_eab2=00 -> 0xFFFF.
//  3. indirect=1, pc=0x3000, sel_eab2=10, ir[8:0]=0x005; mem_ack 3 cycles late with rdata=0x4000
//     -> mem_addr=0x3005 held throughout, ea_out=0x4000.
//  4. out_ready low for 5 cycles in DONE -> ea_out/out_valid stable, in_ready=0, in_valid pulses ignored;
//     out_ready=1 -> IDLE next edge.
//  5. reset asserted while in IND -> mem_req=0 immediately, no out_valid;
//     after release in_ready=1 and a late mem_ack is ignored.
//  6. [EAB_ACV_EN] user_mode=1, direct ea=0x2FFF -> acv=1, mem_req never asserted;
//     user_mode=0 with same ea -> acv=0.

Source files
------------

// File: rtl/eab_agu_if.sv
// Bus bundle for the effective-address unit: request handshake, pointer-read port
// and result handshake. The user_mode/acv pair exists only when EAB_ACV_EN is defined.
interface eab_agu_if #(
   parameter int unsigned DATA_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [10:0]       ir;
   logic [DATA_W-1:0] ra;
   logic [DATA_W-1:0] pc;
   logic              sel_eab1;
   logic [1:0]        sel_eab2;
   logic              indirect;
   logic              mem_req;
   logic [DATA_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] ea_out;
`ifdef EAB_ACV_EN
   logic              user_mode;
   logic              acv;

   modport slave (
      input  in_valid, ir, ra, pc, sel_eab1, sel_eab2, indirect, mem_ack, mem_rdata, out_ready, user_mode,
      output in_ready, mem_req, mem_addr, out_valid, ea_out, acv
   );
   modport master (
      output in_valid, ir, ra, pc, sel_eab1, sel_eab2, indirect, mem_ack, mem_rdata, out_ready, user_mode,
      input  in_ready, mem_req, mem_addr, out_valid, ea_out, acv
   );
`else
   modport slave (
      input  in_valid, ir, ra, pc, sel_eab1, sel_eab2, indirect, mem_ack, mem_rdata, out_ready,
      output in_ready, mem_req, mem_addr, out_valid, ea_out
   );
   modport master (
      output in_valid, ir, ra, pc, sel_eab1, sel_eab2, indirect, mem_ack, mem_rdata, out_ready,
      input  in_ready, mem_req, mem_addr, out_valid, ea_out
   );
`endif
endinterface

// File: rtl/eab_agu.sv
// eab_agu: registered effective-address unit. EA = (PC or Ra) + sext(IR offset),
// optionally followed by one pointer read (LDI/STI style indirection).
// Optional feature macro: EAB_ACV_EN (user-mode access-violation check).
//
// state | meaning
// IDLE  | in_ready high, waiting for a request; operands captured on accept
// CALC  | phase 0: register base+offset; phase 1: finish, or start pointer read
// IND   | phase 0: mem_req held until mem_ack; phase 1: finish with read data
// DONE  | out_valid high, ea_out held until out_ready
//
// Both CALC and IND finish from r_ea in their second phase, so the optional
// privilege check always compares a registered value.
module eab_agu #(
   parameter int unsigned       DATA_W  = 16,
   parameter logic [DATA_W-1:0] SYS_END = 'h3000,
   parameter logic [DATA_W-1:0] IO_BASE = 'hFE00
) (
   input logic      i_clk,
   input logic      i_reset,
   eab_agu_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_IND  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Reject configurations the sign-extension and range check cannot handle.
   if (DATA_W < 12 || SYS_END >= IO_BASE) begin : g_bad_params
      $error("eab_agu: DATA_W must be >= 12 and SYS_END must be below IO_BASE");
   end

   state_t            r_state;
   logic              r_phase;
   logic [10:0]       r_ir;
   logic [DATA_W-1:0] r_ra;
   logic [DATA_W-1:0] r_pc;
   logic              r_sel1;
   logic [1:0]        r_sel2;
   logic              r_ind;
   logic [DATA_W-1:0] r_ea;
   logic              r_in_ready;
   logic              r_mem_req;
   logic [DATA_W-1:0] r_mem_addr;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_ea_out;

   logic [DATA_W-1:0] w_base;
   logic [DATA_W-1:0] w_off;
   logic [DATA_W-1:0] w_sum;
   logic              w_viol;

`ifdef EAB_ACV_EN
   logic r_user;
   logic r_acv;

   assign w_viol  = r_user && ((r_ea < SYS_END) || (r_ea >= IO_BASE));
   assign bus.acv = r_acv;
`else
   assign w_viol = 1'b0;
`endif

   // Base select and sign-extended offset from the captured operands.
   always_comb begin
      w_base = r_sel1 ? r_ra : r_pc;
      w_off  = '0;
      case (r_sel2)
         2'b01:   w_off = {{(DATA_W-11){r_ir[10]}}, r_ir[10:0]};
         2'b10:   w_off = {{(DATA_W-9){r_ir[8]}}, r_ir[8:0]};
         2'b11:   w_off = {{(DATA_W-6){r_ir[5]}}, r_ir[5:0]};
         default: w_off = '0;
      endcase
      w_sum = w_base + w_off;
   end

   // Control FSM with all outputs registered; reset clears any outstanding read.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_phase     <= 1'b0;
         r_ir        <= '0;
         r_ra        <= '0;
         r_pc        <= '0;
         r_sel1      <= 1'b0;
         r_sel2      <= 2'b00;
         r_ind       <= 1'b0;
         r_ea        <= '0;
         r_in_ready  <= 1'b1;
         r_mem_req   <= 1'b0;
         r_mem_addr  <= '0;
         r_out_valid <= 1'b0;
         r_ea_out    <= '0;
`ifdef EAB_ACV_EN
         r_user      <= 1'b0;
         r_acv       <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid && r_in_ready) begin
                  r_ir       <= bus.ir;
                  r_ra       <= bus.ra;
                  r_pc       <= bus.pc;
                  r_sel1     <= bus.sel_eab1;
                  r_sel2     <= bus.sel_eab2;
                  r_ind      <= bus.indirect;
`ifdef EAB_ACV_EN
                  r_user     <= bus.user_mode;
`endif
                  r_phase    <= 1'b0;
                  r_in_ready <= 1'b0;
                  r_state    <= S_CALC;
               end
            end
            S_CALC: begin
               if (!r_phase) begin
                  r_ea    <= w_sum;
                  r_phase <= 1'b1;
               end else begin
                  r_phase <= 1'b0;
                  if (r_ind && !w_viol) begin
                     r_mem_req  <= 1'b1;
                     r_mem_addr <= r_ea;
                     r_state    <= S_IND;
                  end else begin
                     r_ea_out    <= r_ea;
                     r_out_valid <= 1'b1;
`ifdef EAB_ACV_EN
                     r_acv       <= w_viol;
`endif
                     r_state     <= S_DONE;
                  end
               end
            end
            S_IND: begin
               if (!r_phase) begin
                  if (bus.mem_ack) begin
                     r_mem_req <= 1'b0;
                     r_ea      <= bus.mem_rdata;
                     r_phase   <= 1'b1;
                  end
               end else begin
                  r_phase     <= 1'b0;
                  r_ea_out    <= r_ea;
                  r_out_valid <= 1'b1;
`ifdef EAB_ACV_EN
                  r_acv       <= w_viol;
`endif
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
`ifdef EAB_ACV_EN
                  r_acv       <= 1'b0;
`endif
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.out_valid = r_out_valid;
   assign bus.ea_out    = r_ea_out;

endmodule

// File: tb/tb_eab_agu.sv
// Directed bench for eab_agu: table of direct EA vectors plus hand-written
// sequences for indirection, backpressure, mid-read reset and the ACV option.
module tb_eab_agu;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   eab_agu_if #(.DATA_W(DW)) bus();

   eab_agu #(.DATA_W(DW)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus.slave)
   );

   typedef struct {
      logic [15:0] ra;
      logic [15:0] pc;
      logic [10:0] ir;
      logic        sel1;
      logic [1:0]  sel2;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[7];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic [15:0] ra, input logic [15:0] pc, input logic [10:0] ir,
                            input logic s1, input logic [1:0] s2, input logic ind);
      bus.in_valid = 1'b1;
      bus.ra       = ra;
      bus.pc       = pc;
      bus.ir       = ir;
      bus.sel_eab1 = s1;
      bus.sel_eab2 = s2;
      bus.indirect = ind;
   endtask

   // After the accept edge the inputs are garbled to prove they were captured.
   task automatic scramble();
      bus.in_valid = 1'b0;
      bus.ra       = ~bus.ra;
      bus.pc       = ~bus.pc;
      bus.ir       = ~bus.ir;
      bus.sel_eab1 = ~bus.sel_eab1;
      bus.sel_eab2 = ~bus.sel_eab2;
      bus.indirect = ~bus.indirect;
   endtask

   task automatic run_direct(input vec_t v, input string tag);
      chk({tag, "_in_ready_idle"}, bus.in_ready, 1);
      drive_req(v.ra, v.pc, v.ir, v.sel1, v.sel2, 1'b0);
      tick();
      scramble();
      chk({tag, "_in_ready_busy"}, bus.in_ready, 0);
      chk({tag, "_valid_k"}, bus.out_valid, 0);
      tick();
      chk({tag, "_valid_k1"}, bus.out_valid, 0);
      tick();
      chk({tag, "_valid_k2"}, bus.out_valid, 1);
      chk({tag, "_ea"}, bus.ea_out, v.exp);
      chk({tag, "_no_req"}, bus.mem_req, 0);
`ifdef EAB_ACV_EN
      chk({tag, "_acv"}, bus.acv, 0);
`endif
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({tag, "_valid_drop"}, bus.out_valid, 0);
      chk({tag, "_in_ready_back"}, bus.in_ready, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{ra:16'h1111, pc:16'h3000, ir:11'h1FF, sel1:1'b0, sel2:2'b10, exp:16'h2FFF};
      vecs[1] = '{ra:16'hFFFF, pc:16'h2222, ir:11'h001, sel1:1'b1, sel2:2'b11, exp:16'h0000};
      vecs[2] = '{ra:16'hFFFF, pc:16'h2222, ir:11'h7FF, sel1:1'b1, sel2:2'b00, exp:16'hFFFF};
      vecs[3] = '{ra:16'h5555, pc:16'h1234, ir:11'h400, sel1:1'b0, sel2:2'b01, exp:16'h0E34};
      vecs[4] = '{ra:16'h4000, pc:16'h0100, ir:11'h7E0, sel1:1'b1, sel2:2'b11, exp:16'h3FE0};
      vecs[5] = '{ra:16'h0AAA, pc:16'h3000, ir:11'h6FF, sel1:1'b0, sel2:2'b10, exp:16'h30FF};
      vecs[6] = '{ra:16'h0010, pc:16'h8000, ir:11'h3FF, sel1:1'b1, sel2:2'b01, exp:16'h040F};

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.ir        = '0;
      bus.ra        = '0;
      bus.pc        = '0;
      bus.sel_eab1  = 1'b0;
      bus.sel_eab2  = 2'b00;
      bus.indirect  = 1'b0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      bus.out_ready = 1'b0;
`ifdef EAB_ACV_EN
      bus.user_mode = 1'b0;
`endif
      tick();
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_ea_out", bus.ea_out, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
`ifdef EAB_ACV_EN
      chk("rst_acv", bus.acv, 0);
`endif
      rst = 1'b0;
      tick();

      for (int i = 0; i < 7; i++) begin
         run_direct(vecs[i], $sformatf("vec%0d", i));
      end

      // Indirect: stray ack in CALC ignored, pointer read acked 3 cycles late.
      chk("ind_in_ready", bus.in_ready, 1);
      drive_req(16'h1111, 16'h3000, 11'h005, 1'b0, 2'b10, 1'b1);
      tick();
      scramble();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'hBEEF;
      chk("ind_req_k", bus.mem_req, 0);
      tick();
      bus.mem_ack = 1'b0;
      chk("ind_req_k1", bus.mem_req, 0);
      chk("ind_valid_k1", bus.out_valid, 0);
      tick();
      chk("ind_req_k2", bus.mem_req, 1);
      chk("ind_addr_k2", bus.mem_addr, 16'h3005);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("ind_hold_req%0d", i), bus.mem_req, 1);
         chk($sformatf("ind_hold_addr%0d", i), bus.mem_addr, 16'h3005);
         chk($sformatf("ind_hold_valid%0d", i), bus.out_valid, 0);
      end
      bus.out_ready = 1'b0;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'h4000;
      tick();
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 16'hDEAD;
      chk("ind_req_drop", bus.mem_req, 0);
      chk("ind_valid_ack", bus.out_valid, 0);
      tick();
      chk("ind_valid", bus.out_valid, 1);
      chk("ind_ea", bus.ea_out, 16'h4000);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("ind_valid_drop", bus.out_valid, 0);
      chk("ind_in_ready_back", bus.in_ready, 1);

      // Backpressure: DONE held 5 cycles while in_valid pulses are ignored.
      drive_req(vecs[3].ra, vecs[3].pc, vecs[3].ir, vecs[3].sel1, vecs[3].sel2, 1'b0);
      tick();
      scramble();
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         drive_req(16'h0100 + 16'(i), 16'h0200, 11'h0FF, 1'b1, 2'b01, 1'b0);
         bus.in_valid = (i % 2 == 0);
         tick();
         chk($sformatf("bp_valid%0d", i), bus.out_valid, 1);
         chk($sformatf("bp_ea%0d", i), bus.ea_out, 16'h0E34);
         chk($sformatf("bp_in_ready%0d", i), bus.in_ready, 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("bp_valid_drop", bus.out_valid, 0);
      chk("bp_in_ready", bus.in_ready, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("bp_idle_valid%0d", i), bus.out_valid, 0);
         chk($sformatf("bp_idle_ready%0d", i), bus.in_ready, 1);
      end

      // Reset during a pointer read, then a late ack.
      drive_req(16'h1111, 16'h3000, 11'h005, 1'b0, 2'b10, 1'b1);
      tick();
      scramble();
      tick();
      tick();
      chk("rind_req_before", bus.mem_req, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("rind_req_async", bus.mem_req, 0);
      chk("rind_addr_async", bus.mem_addr, 0);
      chk("rind_valid_async", bus.out_valid, 0);
      chk("rind_in_ready_async", bus.in_ready, 1);
      tick();
      rst           = 1'b0;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'h5555;
      tick();
      bus.mem_ack = 1'b0;
      chk("rind_late_req", bus.mem_req, 0);
      chk("rind_late_valid", bus.out_valid, 0);
      chk("rind_late_ready", bus.in_ready, 1);
      tick();
      chk("rind_late_valid2", bus.out_valid, 0);
      run_direct(vecs[0], "rind_recover");

`ifdef EAB_ACV_EN
      // User-mode pointer below SYS_END: violation, no read issued.
      bus.user_mode = 1'b1;
      drive_req(vecs[0].ra, vecs[0].pc, vecs[0].ir, vecs[0].sel1, vecs[0].sel2, 1'b1);
      tick();
      scramble();
      chk("acv_req_k", bus.mem_req, 0);
      tick();
      chk("acv_req_k1", bus.mem_req, 0);
      tick();
      chk("acv_req_k2", bus.mem_req, 0);
      chk("acv_valid", bus.out_valid, 1);
      chk("acv_flag", bus.acv, 1);
      chk("acv_ea", bus.ea_out, 16'h2FFF);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("acv_valid_drop", bus.out_valid, 0);
      run_direct(vecs[5], "acv_user_ok");
      bus.user_mode = 1'b0;
      run_direct(vecs[0], "acv_super");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
